rf_multiport: RTL



---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_bypass_mux.sv | 35 +++
 rtl/rf_multiport.sv | 119 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and flush FSM encoding for the multiport register file.
package rf_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_IDX = 0;

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port output select: array word, same-cycle write bypass, zero register, sweep blanking.
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] word,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              busy,
  output logic [DATA_W-1:0] rd
);

  logic zero_hit;
  assign zero_hit = (ZERO_REG != 0) && (ra == ADDR_W'(RF_ZERO_IDX));

  // Port 1 is evaluated last so it wins when both write ports match.
  always_comb begin
    rd = word;
    if (BYPASS != 0) begin
      if (we0 && (wa0 == ra)) rd = wd0;
      if (we1 && (wa1 == ra)) rd = wd1;
    end
    if (zero_hit || busy) rd = '0;
  end

endmodule

// File: rtl/rf_multiport.sv
// Multiport GPR file: NUM_RD comb reads, two prioritised write ports, background flush sweep.
// Define RF_TRACE_EN to print one trace line per committed write.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [31:0]              pc0,
  input  logic [31:0]              pc1,
  input  logic                     flush_req,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  logic [NUM_RD-1:0][ADDR_W-1:0] ra_v;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_v;

  assign ra_v = ra;
  assign rd   = rd_v;
  assign busy = (state == ST_SWEEP);

  logic zt0, zt1, commit0, commit1;
  assign zt0 = (ZERO_REG != 0) && (wa0 == ADDR_W'(RF_ZERO_IDX));
  assign zt1 = (ZERO_REG != 0) && (wa1 == ADDR_W'(RF_ZERO_IDX));
  assign commit1 = we1 && !busy && !zt1;
  // Port 0 loses an address collision even when port 1 targets the zero register.
  assign commit0 = we0 && !busy && !zt0 && !(we1 && (wa1 == wa0));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (flush_req) begin
          state_nxt = ST_SWEEP;
          idx_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        idx_nxt = idx + 1'b1;
        if (&idx) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[idx] <= '0;
    end else begin
      if (commit0) mem[wa0] <= wd0;
      if (commit1) mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_bypass_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_mux (
      .ra  (ra_v[k]),
      .word(mem[ra_v[k]]),
      .we0 (we0),
      .wa0 (wa0),
      .wd0 (wd0),
      .we1 (we1),
      .wa1 (wa1),
      .wd1 (wd1),
      .busy(busy),
      .rd  (rd_v[k])
    );
  end

`ifdef RF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (commit0) $display("%0t@%h: $%0d <= %h", $time, pc0 - 32'd4, wa0, wd0);
      if (commit1) $display("%0t@%h: $%0d <= %h", $time, pc1 - 32'd4, wa1, wd1);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^{pc0, pc1};
`endif

endmodule
